// File: rtl/truth_table_sweeper.sv
// Drives every input combination of an N_IN-input gate in ascending order, samples F/Fn after
// a settle window and builds a registered truth table, minterm count and complement-error flag.
module truth_table_sweeper #(
   parameter int unsigned N_IN          = 3,
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [N_IN-1:0]      xyz,
   input  logic                 f_in,
   input  logic                 fn_in,
   output logic                 busy,
   output logic                 done,
   output logic [2**N_IN-1:0]  table_out,
   output logic [N_IN:0]        minterm_cnt,
   output logic                 err
);

   localparam int unsigned N_VEC = 2**N_IN;

   typedef enum logic [1:0] {StIdle, StDrive, StDone} state_e;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [3:0]        settle_q, settle_d;
   logic [N_VEC-1:0]  table_q, table_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic              err_q, err_d;
   logic              busy_q, done_q;
   logic              last_settle;

   assign last_settle = (settle_q == 4'(SETTLE_CYCLES - 1));

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      settle_d = settle_q;
      table_d  = table_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d  = StDrive;
               idx_d    = '0;
               settle_d = '0;
               table_d  = '0;
               cnt_d    = '0;
               err_d    = 1'b0;
            end
         end
         StDrive: begin
            // Sample only on the last cycle of the hold window so early glitches are ignored.
            if (last_settle) begin
               table_d[idx_q] = f_in;
               cnt_d          = cnt_q + (N_IN+1)'(f_in);
               err_d          = err_q | (f_in == fn_in);
               settle_d       = '0;
               if (&idx_q) begin
                  state_d = StDone;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_q + N_IN'(1);
               end
            end else begin
               settle_d = settle_q + 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         settle_q <= '0;
         table_q  <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         settle_q <= settle_d;
         table_q  <= table_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         busy_q   <= (state_d == StDrive);
         done_q   <= (state_d == StDone);
      end
   end

   // idx is forced to 0 outside DRIVE, so it doubles as the registered drive vector.
   assign xyz         = idx_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign table_out   = table_q;
   assign minterm_cnt = cnt_q;
   assign err         = err_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a glitchy gate model with optional Fn fault, checked against
// truth tables and counts computed directly from the gate function.
module tb_truth_table_sweeper;

   localparam int SA = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_a, start_b;
   logic [2:0] xyz_a, xyz_b;
   logic       f_a = 1'b0, fn_a = 1'b1;
   logic       f_b, fn_b;
   logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
   logic [7:0] table_a, table_b;
   logic [3:0] cnt_a, cnt_b;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] tt = 8'h3A;
   logic       fault_en = 1'b0;
   logic [2:0] fault_vec = 3'd0;
   int         hold = 0;
   logic       prev_busy = 1'b0;
   logic [2:0] prev_xyz = 3'd0;

   assign f_b = 1'b1;

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(SA)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .xyz(xyz_a), .f_in(f_a), .fn_in(fn_a),
      .busy(busy_a), .done(done_a), .table_out(table_a), .minterm_cnt(cnt_a), .err(err_a)
   );

   truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(1)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .xyz(xyz_b), .f_in(f_b), .fn_in(fn_b),
      .busy(busy_b), .done(done_b), .table_out(table_b), .minterm_cnt(cnt_b), .err(err_b)
   );

   always #5 clk = ~clk;

   // Gate model: random outputs until the last cycle a vector is held, then the true function.
   always @(posedge clk) begin
      #1;
      if (!busy_a || !prev_busy || xyz_a != prev_xyz) hold = 0;
      else hold++;
      prev_busy = busy_a;
      prev_xyz  = xyz_a;
      if (busy_a && hold < SA - 1) begin
         f_a  = 1'($urandom);
         fn_a = 1'($urandom);
      end else begin
         f_a  = tt[xyz_a];
         fn_a = (fault_en && xyz_a == fault_vec) ? f_a : ~f_a;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic sweep_a(input logic [7:0] t, input logic flt, input logic [2:0] fv,
                          input bit mid, input string tag);
      int m;
      bit seq_ok;
      tt = t;
      fault_en = flt;
      fault_vec = fv;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      check({tag, "_clr"}, {table_a, cnt_a, err_a}, 0);
      m = 0;
      seq_ok = 1'b1;
      while (!done_a && m < 64) begin
         if (xyz_a != 3'(m / SA) || !busy_a) seq_ok = 1'b0;
         start_a = (mid && m == 6);
         @(negedge clk);
         m++;
      end
      start_a = 1'b0;
      check({tag, "_lat"}, m, 16);
      check({tag, "_seq"}, seq_ok, 1);
      check({tag, "_tab"}, table_a, t);
      check({tag, "_cnt"}, cnt_a, $countones(t));
      check({tag, "_err"}, err_a, flt);
      check({tag, "_end"}, {busy_a, xyz_a}, 0);
      @(negedge clk);
      check({tag, "_pulse"}, {done_a, busy_a}, 0);
      @(negedge clk);
      check({tag, "_idle"}, busy_a, 0);
   endtask

   task automatic sweep_b(input logic fv);
      int m;
      fn_b = fv;
      @(negedge clk) start_b = 1'b1;
      @(negedge clk) start_b = 1'b0;
      m = 0;
      while (!done_b && m < 64) begin
         @(negedge clk);
         m++;
      end
      check("b_lat", m, 8);
      check("b_tab", table_b, 8'hFF);
      check("b_cnt", cnt_b, 8);
      check("b_err", err_b, fv);
      check("b_xyz", xyz_b, 0);
   endtask

   initial begin
      int m;
      int d1;
      int d2;
      bit bad;
      rst = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      fn_b = 1'b0;
      #2 rst = 1'b1;
      #1;
      check("rst_a", {xyz_a, busy_a, done_a, table_a, cnt_a, err_a}, 0);
      check("rst_b", {xyz_b, busy_b, done_b, table_b, cnt_b, err_b}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (done_a || busy_a || xyz_a != 0 || table_a != 0 || err_a) bad = 1'b1;
      end
      check("idle20", bad, 0);

      sweep_a(8'h3A, 1'b0, 3'd0, 1'b0, "gate");
      sweep_a(8'h3A, 1'b1, 3'd5, 1'b0, "fault");
      repeat (5) @(negedge clk);
      check("err_sticky", err_a, 1);
      sweep_a(8'h3A, 1'b0, 3'd0, 1'b1, "mid");

      // Abort a sweep by reset partway through vector 4.
      fault_en = 1'b1;
      fault_vec = 3'd1;
      @(negedge clk) start_a = 1'b1;
      @(negedge clk) start_a = 1'b0;
      m = 0;
      while (xyz_a != 3'd4 && m < 64) begin
         @(negedge clk);
         m++;
      end
      check("rst_reach", xyz_a, 4);
      #2 rst = 1'b1;
      #1;
      check("rst_mid", {xyz_a, busy_a, done_a, table_a, cnt_a, err_a}, 0);
      @(negedge clk) rst = 1'b0;
      sweep_a(8'h3A, 1'b0, 3'd0, 1'b0, "post_rst");

      // Start held high re-triggers from IDLE every 18 cycles.
      tt = 8'h3A;
      fault_en = 1'b0;
      @(negedge clk) start_a = 1'b1;
      m = 0;
      d1 = -1;
      d2 = -1;
      while (m < 100 && d2 < 0) begin
         @(negedge clk);
         m++;
         if (done_a) begin
            if (d1 < 0) d1 = m;
            else d2 = m;
         end
      end
      start_a = 1'b0;
      check("held_first", d1, 17);
      check("held_period", d2 - d1, 18);
      check("held_tab", table_a, 8'h3A);
      repeat (3) @(negedge clk);
      check("held_stop", busy_a, 0);

      for (int i = 0; i < 6; i++) begin
         sweep_a(8'($urandom), 1'($urandom), 3'($urandom), 1'b0, $sformatf("rnd%0d", i));
      end

      sweep_b(1'b0);
      sweep_b(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Sequential stimulus/capture stage that sits directly in front of the 3-input combinational gate stage (sop/pos gate with outputs F and Fn).
- On a start request it drives every input combination onto x,y,z in ascending order and samples the returned F/Fn after a settle window.
- It builds a registered truth table and minterm count, and flags any F/Fn complement violation.
- It is the synthesizable replacement for hand-written #50 stimulus benches.

Parameters:
- N_IN, 3, number of gate inputs driven; vector width.
- SETTLE_CYCLES, 2, clock cycles each vector is held before sampling; legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  sweep request, sampled only in IDLE.
- xyz  output  N_IN  drive vector to gate; MSB = x, then y, LSB = z.
- f_in  input  1  F returned from gate.
- fn_in  input  1  Fn returned from gate.
- busy  output  1  high while sweep in progress (DRIVE state).
- done  output  1  one-cycle pulse at sweep completion.
- table_out  output  2**N_IN  captured truth table; bit i = F for xyz==i.
- minterm_cnt  output  N_IN+1  number of vectors with F=1.
- err  output  1  sticky flag; set if any sample had f_in == fn_in.

Behaviour:
- Reset (async, immediate): state=IDLE, xyz=0, busy=0, done=0, table_out=0, minterm_cnt=0, err=0, idx=0, settle=0. Reset mid-sweep aborts with no partial results retained.
- States: IDLE, DRIVE, DONE.
- IDLE:
  - xyz holds 0.
  - start=1 at an edge -> DRIVE, idx=0, settle=0; clears table_out, minterm_cnt and err on the same edge.
- DRIVE:
  - xyz = idx (registered); busy=1.
  - settle increments each edge.
  - At the edge where settle==SETTLE_CYCLES-1: table_out[idx]<=f_in; minterm_cnt += f_in; err <= err | (f_in==fn_in); settle<=0.
  - At that same edge: if idx==2**N_IN-1 -> DONE, else idx+1.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - xyz returns to 0.
  - Next edge -> IDLE unconditionally.
- start:
  - Ignored in DRIVE and DONE; no queuing.
  - start held high continuously re-triggers from IDLE, so a new sweep begins every 2**N_IN*SETTLE_CYCLES+2 cycles.
- Latency:
  - First vector appears the cycle after the start edge.
  - done asserts 2**N_IN*SETTLE_CYCLES cycles after the start edge (16 with defaults).
- Results:
  - table_out, minterm_cnt and err hold stable from DONE until the next accepted start or reset.
  - minterm_cnt never wraps; its width covers the value 2**N_IN.
- Sampling occurs only on the final settle cycle; glitches on f_in/fn_in earlier in the window are ignored.
- All outputs are registered; no combinational path from f_in/fn_in to any output.

Test Plan:
- Reset then idle, start=0 for 20 cycles -> xyz=0, busy=0, done never asserts, table_out=0x00, err=0.
- Connected to gate F=(x+z)(x'+y'), Fn=~F, pulse start -> xyz steps 0..7, each held 2 cycles; done pulses 16 cycles after start; table_out=8'h3A, minterm_cnt=4, err=0.
- Same sweep with fn_in forced equal to f_in on vector 5 only -> table_out=8'h3A, err=1; err stays 1 until the next start.
- Start asserted again while busy (mid-sweep, idx=3) -> ignored; sweep completes unchanged with a single done pulse.
- rst asserted asynchronously at idx=4 -> all outputs 0 immediately. Release rst and start -> a clean full sweep gives table_out=8'h3A.
- SETTLE_CYCLES=1, f_in tied to 1 -> done 8 cycles after start, table_out=8'hFF, minterm_cnt=8, err=1 if fn_in is tied to 1, else 0.
